bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: slave cycles without ack before the error-ack fires (range 2..255).
REQ-002 clk  input  1  single system clock; all state rising-edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 m0_stb_i  input  1  master 0 (CPU) strobe; held until ack.
REQ-005 m0_we_i  input  1  master 0 write enable.
REQ-006 m0_adr_i  input  32  master 0 byte address; [31:24] = bank.
REQ-007 m0_sel_i  input  4  master 0 byte lane selects.
REQ-008 m0_dat_i  input  32  master 0 write data.
REQ-009 m0_ack_o  output  1  master 0 transfer done.
REQ-010 m0_err_o  output  1  master 0 transfer failed; valid with m0_ack_o.
REQ-011 m0_dat_o  output  32  master 0 read data; valid with m0_ack_o.
REQ-012 m1_* (DMA master): identical set to REQ-004..REQ-011 with prefix m1_.
REQ-013 s_stb_o  output  5  one-hot strobe per bank 0..4 (ram, led, video, uart, enet).
REQ-014 s_we_o / s_adr_o / s_sel_o / s_dat_o  output  1/32/4/32  shared slave bus, from the owning master.
REQ-015 s_ack_i  input  5  per-bank ack.
REQ-016 s_dat_i  input  160  per-bank read data; bank n at [32n+31:32n].
REQ-017 grant_o  output  2  one-hot current owner, 00 when idle.

Function
REQ-018 FSM states IDLE, OWN0, OWN1; grant_o = {state==OWN1, state==OWN0}.
REQ-019 IDLE: s_stb_o=0, all master acks/errs=0, s_we_o/s_adr_o/s_sel_o/s_dat_o=0.
REQ-020 IDLE arbitration: only mX_stb_i high -> OWNX next cycle; both high -> grant the master not served last (last_q), so grant latency is exactly 1 cycle.
REQ-021 OWNX: s_we/adr/sel/dat driven combinationally from master X; s_stb_o[bank]=mX_stb_i when bank<5, else 0.
REQ-022 OWNX: mX_ack_o=s_ack_i[bank], mX_dat_o=s_dat_i[bank], mX_err_o=0, combinational (zero-wait slaves such as RAM complete in the first owned cycle).
REQ-023 Non-owner ack/err/dat outputs SHALL be 0 at all times.
REQ-024 Unmapped bank (>=5) while owned: no slave strobe; mX_ack_o=1, mX_err_o=1, mX_dat_o=0 for exactly one cycle, first owned cycle.
REQ-025 8-bit wait counter: cleared on entry to OWNX, increments each owned cycle without ack; when it equals TIMEOUT-1 and no ack: mX_ack_o=1, mX_err_o=1, mX_dat_o=0, s_stb_o forced 0 that cycle.
REQ-026 Any ack to owner (normal, unmapped, timeout) -> IDLE next cycle, last_q<=X; one idle cycle between back-to-back grants.
REQ-027 Owner drops mX_stb_i before ack (abort) -> IDLE next cycle, no ack, last_q<=X.
REQ-028 Simultaneous slave ack and timeout terminal count: normal ack wins, err=0.
REQ-029 Ack on a bank not currently strobed SHALL be ignored.

Reset
REQ-030 rst_ni low asynchronously forces state=IDLE, last_q=1 (m0 wins first contention), counter=0; all outputs 0 while low.
REQ-031 Reset mid-transfer drops the transfer without ack; first grant after release follows REQ-020.

Structure
REQ-032 Shared package holds bank constants (BANK_RAM=0, BANK_LED=1, BANK_VIDEO=2, BANK_UART=3, BANK_ENET=4, NBANK=5) and the state encoding.
REQ-033 No sub-modules; one combinational mux/decode section plus one registered FSM/counter section.

Verification
REQ-034 m0 read adr 0x00000010, s_ack_i[0] same cycle, s_dat_i bank0=0x12345678 -> m0_ack_o=1, m0_dat_o=0x12345678 one cycle after m0_stb_i rises; grant_o=01.
REQ-035 m0 and m1 strobe together after reset, repeated 4 times -> grants m0,m1,m0,m1 with one IDLE cycle between.
REQ-036 m1 write adr 0x03000000 dat 0x41, uart acks after 3 waits -> s_stb_o=01000 for 4 cycles, s_dat_o=0x41, m1_ack_o on 4th owned cycle.
REQ-037 m0 read adr 0x07000000 -> m0_ack_o=1, m0_err_o=1, m0_dat_o=0, s_stb_o=00000 throughout.
REQ-038 m0 read bank 2, video never acks, TIMEOUT=64 -> m0_ack_o/m0_err_o=1 on owned cycle 64, then IDLE; rst_ni pulsed low mid-wait in repeat run -> grant_o=00 immediately, no ack.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master, five-bank bus arbiter:
// bank map, FSM state encoding and the per-master request bundle.
package bus_arbiter_pkg;

    localparam int unsigned BANK_RAM   = 0;
    localparam int unsigned BANK_LED   = 1;
    localparam int unsigned BANK_VIDEO = 2;
    localparam int unsigned BANK_UART  = 3;
    localparam int unsigned BANK_ENET  = 4;
    localparam int unsigned NBANK      = BANK_ENET + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    typedef struct packed {
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } mreq_t;

    function automatic logic bank_mapped(input logic [7:0] bank);
        return ({24'd0, bank} < NBANK);
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (CPU, DMA) arbiter onto a shared five-bank slave bus with
// fair alternation on contention, unmapped-bank error and wait timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_ni,

    input  logic         m0_stb_i,
    input  logic         m0_we_i,
    input  logic [31:0]  m0_adr_i,
    input  logic [3:0]   m0_sel_i,
    input  logic [31:0]  m0_dat_i,
    output logic         m0_ack_o,
    output logic         m0_err_o,
    output logic [31:0]  m0_dat_o,

    input  logic         m1_stb_i,
    input  logic         m1_we_i,
    input  logic [31:0]  m1_adr_i,
    input  logic [3:0]   m1_sel_i,
    input  logic [31:0]  m1_dat_i,
    output logic         m1_ack_o,
    output logic         m1_err_o,
    output logic [31:0]  m1_dat_o,

    output logic [4:0]   s_stb_o,
    output logic         s_we_o,
    output logic [31:0]  s_adr_o,
    output logic [3:0]   s_sel_o,
    output logic [31:0]  s_dat_o,
    input  logic [4:0]   s_ack_i,
    input  logic [159:0] s_dat_i,

    output logic [1:0]   grant_o
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT must lie in 2..255");
    end

    state_e      state_q;
    logic        last_q;
    logic [7:0]  cnt_q;

    mreq_t       m0_req;
    mreq_t       m1_req;
    mreq_t       own_req;
    logic        owned;
    logic        own_sel;
    logic [7:0]  bank;
    logic        mapped;
    logic        hit_ack;
    logic [31:0] hit_dat;
    logic        tmo;
    logic        active;
    logic        ack_ok;
    logic        err_unm;
    logic        err_tmo;
    logic        done;
    logic        err;
    logic [31:0] rdat;

    assign m0_req = {m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i};
    assign m1_req = {m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i};

    assign grant_o = {state_q == ST_OWN1, state_q == ST_OWN0};

    always_comb begin
        owned   = (state_q != ST_IDLE);
        own_sel = (state_q == ST_OWN1);
        own_req = '0;
        if (state_q == ST_OWN0) begin
            own_req = m0_req;
        end else if (state_q == ST_OWN1) begin
            own_req = m1_req;
        end

        bank    = own_req.adr[31:24];
        mapped  = bank_mapped(bank);
        hit_ack = 1'b0;
        hit_dat = '0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            if (bank == 8'(i)) begin
                hit_ack = s_ack_i[i];
                hit_dat = s_dat_i[32*i +: 32];
            end
        end

        // A real slave ack in the terminal-count cycle takes precedence over the timeout.
        tmo     = (cnt_q == 8'(TIMEOUT - 1));
        active  = owned && own_req.stb;
        ack_ok  = active && mapped && hit_ack;
        err_unm = active && !mapped;
        err_tmo = active && mapped && !hit_ack && tmo;
        done    = ack_ok || err_unm || err_tmo;
        err     = err_unm || err_tmo;
        rdat    = (owned && mapped && !err_tmo) ? hit_dat : '0;

        s_stb_o = '0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            s_stb_o[i] = active && mapped && !err_tmo && (bank == 8'(i));
        end
        s_we_o  = own_req.we;
        s_adr_o = own_req.adr;
        s_sel_o = own_req.sel;
        s_dat_o = own_req.dat;

        m0_ack_o = (state_q == ST_OWN0) && done;
        m0_err_o = (state_q == ST_OWN0) && err;
        m0_dat_o = (state_q == ST_OWN0) ? rdat : '0;
        m1_ack_o = (state_q == ST_OWN1) && done;
        m1_err_o = (state_q == ST_OWN1) && err;
        m1_dat_o = (state_q == ST_OWN1) ? rdat : '0;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (m0_stb_i && m1_stb_i) begin
                        state_q <= last_q ? ST_OWN0 : ST_OWN1;
                    end else if (m0_stb_i) begin
                        state_q <= ST_OWN0;
                    end else if (m1_stb_i) begin
                        state_q <= ST_OWN1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (!own_req.stb || done) begin
                        state_q <= ST_IDLE;
                        last_q  <= own_sel;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios followed by randomized traffic, every cycle checked
// against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic [1:0]   m_stb = '0;
    logic [1:0]   m_we = '0;
    logic [31:0]  m_adr [2];
    logic [3:0]   m_sel [2];
    logic [31:0]  m_wdat [2];
    logic [4:0]   s_ack = '0;
    logic [159:0] s_dat = '0;

    logic         m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0]  m0_dat, m1_dat;
    logic [4:0]   s_stb;
    logic         s_we;
    logic [31:0]  s_adr, s_sdat;
    logic [3:0]   s_sel;
    logic [1:0]   grant;

    int checks = 0;
    int errors = 0;

    // Model state: owner (-1 idle), wait cycles so far, last served master.
    int own = -1, cnt = 0, last = 1;
    int nxt_own, nxt_cnt, nxt_last;
    logic [1:0] got_ack;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_adr_i(m_adr[0]),
        .m0_sel_i(m_sel[0]), .m0_dat_i(m_wdat[0]),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_dat),
        .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_adr_i(m_adr[1]),
        .m1_sel_i(m_sel[1]), .m1_dat_i(m_wdat[1]),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_dat),
        .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_sel_o(s_sel),
        .s_dat_o(s_sdat), .s_ack_i(s_ack), .s_dat_i(s_dat),
        .grant_o(grant)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs stable: checks outputs against the model.
    task automatic settle();
        logic [1:0]  e_ack, e_err, dchk;
        logic [31:0] e_dat [2];
        logic [4:0]  e_stb;
        logic        e_we;
        logic [31:0] e_adr, e_sdat;
        logic [3:0]  e_sel;
        logic [1:0]  e_grant;
        int          bank;
        bit          done;
        #1;
        if (!rst_ni) begin
            own = -1; cnt = 0; last = 1;
        end
        e_ack = '0; e_err = '0; e_stb = '0; e_we = 1'b0;
        e_adr = '0; e_sdat = '0; e_sel = '0;
        e_dat[0] = '0; e_dat[1] = '0; done = 1'b0;
        nxt_own = own; nxt_cnt = cnt; nxt_last = last;
        if (!rst_ni) begin
            nxt_own = -1;
        end else if (own < 0) begin
            nxt_cnt = 0;
            if (m_stb[0] && m_stb[1]) nxt_own = 1 - last;
            else if (m_stb[0])        nxt_own = 0;
            else if (m_stb[1])        nxt_own = 1;
        end else begin
            e_we = m_we[own]; e_adr = m_adr[own]; e_sel = m_sel[own]; e_sdat = m_wdat[own];
            bank = int'(m_adr[own][31:24]);
            if (!m_stb[own]) begin
                done = 1'b1;
            end else if (bank >= 5) begin
                e_ack[own] = 1'b1; e_err[own] = 1'b1; done = 1'b1;
            end else if (s_ack[bank]) begin
                e_ack[own] = 1'b1; e_dat[own] = s_dat[32*bank +: 32];
                e_stb[bank] = 1'b1; done = 1'b1;
            end else if (cnt == TMO - 1) begin
                e_ack[own] = 1'b1; e_err[own] = 1'b1; done = 1'b1;
            end else begin
                e_stb[bank] = 1'b1; nxt_cnt = cnt + 1;
            end
            if (done) begin
                nxt_own = -1; nxt_last = own; nxt_cnt = 0;
            end
        end
        dchk[0] = (own != 0) || e_ack[0];
        dchk[1] = (own != 1) || e_ack[1];
        got_ack = e_ack;
        e_grant = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        chk("grant", 32'(grant), 32'(e_grant));
        chk("s_stb", 32'(s_stb), 32'(e_stb));
        chk("s_we", 32'(s_we), 32'(e_we));
        chk("s_adr", s_adr, e_adr);
        chk("s_sel", 32'(s_sel), 32'(e_sel));
        chk("s_dat", s_sdat, e_sdat);
        chk("m0_ack", 32'(m0_ack), 32'(e_ack[0]));
        chk("m0_err", 32'(m0_err), 32'(e_err[0]));
        chk("m1_ack", 32'(m1_ack), 32'(e_ack[1]));
        chk("m1_err", 32'(m1_err), 32'(e_err[1]));
        if (dchk[0]) chk("m0_dat", m0_dat, e_dat[0]);
        if (dchk[1]) chk("m1_dat", m1_dat, e_dat[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        own = nxt_own; cnt = nxt_cnt; last = nxt_last;
        @(negedge clk);
    endtask

    task automatic set_m(input int m, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_stb[m] = stb; m_we[m] = we; m_adr[m] = adr; m_sel[m] = 4'hF; m_wdat[m] = dat;
    endtask

    task automatic new_txn(input int m);
        logic [31:0] r;
        logic [7:0]  b;
        r = $urandom();
        b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4));
        m_stb[m] = 1'b1; m_we[m] = 1'($urandom_range(0, 1));
        m_adr[m] = {b, r[23:0]}; m_sel[m] = 4'($urandom_range(0, 15)); m_wdat[m] = $urandom();
    endtask

    initial begin
        set_m(0, 0, 0, '0, '0);
        set_m(1, 0, 0, '0, '0);
        @(negedge clk);

        // Reset state
        settle(); chk("rst_grant", 32'(grant), 32'd0); tick();
        settle(); tick();
        rst_ni = 1'b1;
        settle(); tick();

        // Zero-wait RAM read
        set_m(0, 1, 0, 32'h0000_0010, '0);
        s_ack = 5'b00001; s_dat[31:0] = 32'h1234_5678;
        settle(); chk("ram_idle_ack", 32'(m0_ack), 32'd0); tick();
        settle();
        chk("ram_ack", 32'(m0_ack), 32'd1);
        chk("ram_dat", m0_dat, 32'h1234_5678);
        chk("ram_grant", 32'(grant), 32'd1);
        tick();
        m_stb[0] = 1'b0; s_ack = '0;
        settle(); tick();

        // Contention after reset alternates m0, m1 with an idle gap
        rst_ni = 1'b0; settle(); tick(); rst_ni = 1'b1;
        set_m(0, 1, 0, 32'h0000_0100, '0);
        set_m(1, 1, 1, 32'h0000_0200, 32'hAB);
        s_ack = 5'b11111;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] seq [8];
            seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
            settle(); chk("alt_grant", 32'(grant), 32'(seq[k])); tick();
        end
        m_stb = '0; s_ack = '0;
        settle(); tick();

        // UART write with three wait states
        set_m(1, 1, 1, 32'h0300_0000, 32'h41);
        settle(); tick();
        for (int k = 1; k <= 4; k++) begin
            s_ack = (k == 4) ? 5'b01000 : 5'b00000;
            settle();
            chk("uart_stb", 32'(s_stb), 32'b01000);
            chk("uart_dat", s_sdat, 32'h41);
            chk("uart_ack", 32'(m1_ack), (k == 4) ? 32'd1 : 32'd0);
            tick();
        end
        m_stb[1] = 1'b0; s_ack = '0;
        settle(); tick();

        // Unmapped bank
        set_m(0, 1, 0, 32'h0700_0000, '0);
        s_ack = 5'b11111; s_dat = {5{32'hFFFF_FFFF}};
        settle(); chk("unm_stb0", 32'(s_stb), 32'd0); tick();
        settle();
        chk("unm_ack", 32'(m0_ack), 32'd1);
        chk("unm_err", 32'(m0_err), 32'd1);
        chk("unm_dat", m0_dat, 32'd0);
        chk("unm_stb1", 32'(s_stb), 32'd0);
        tick();
        m_stb[0] = 1'b0; s_ack = '0;
        settle(); tick();

        // Video timeout, other banks acking meanwhile
        set_m(0, 1, 0, 32'h0200_0040, '0);
        s_ack = 5'b11011;
        settle(); tick();
        for (int k = 1; k <= TMO; k++) begin
            settle();
            chk("tmo_ack", 32'(m0_ack), (k == TMO) ? 32'd1 : 32'd0);
            chk("tmo_err", 32'(m0_err), (k == TMO) ? 32'd1 : 32'd0);
            chk("tmo_stb", 32'(s_stb), (k == TMO) ? 32'd0 : 32'b00100);
            tick();
        end
        m_stb[0] = 1'b0;
        settle(); chk("tmo_idle", 32'(grant), 32'd0); tick();

        // Same wait cut short by reset
        m_stb[0] = 1'b1;
        settle(); tick();
        for (int k = 1; k <= 30; k++) begin settle(); tick(); end
        rst_ni = 1'b0;
        settle();
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_ack", 32'(m0_ack), 32'd0);
        tick();
        rst_ni = 1'b1; m_stb[0] = 1'b0; s_ack = '0;
        settle(); tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            settle();
            tick();
            for (int m = 0; m < 2; m++) begin
                if (m_stb[m] && got_ack[m]) begin
                    if ($urandom_range(0, 1) == 0) new_txn(m); else m_stb[m] = 1'b0;
                end else if (m_stb[m]) begin
                    if ($urandom_range(0, 39) == 0) m_stb[m] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_txn(m);
                end
            end
            for (int b = 0; b < 5; b++) s_ack[b] = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < 5; b++) s_dat[32*b +: 32] = $urandom();
            rst_ni = ($urandom_range(0, 199) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
